// File: rtl/prog_memory.sv
// prog_memory: run-time loadable instruction RAM for the 16-bit core.
// A byte-stream loader fills the RAM MSB-first. Fetches return a registered word
// one cycle after the request. Any address outside the loaded program reads as NOP (0).
//
// state | meaning
// IDLE  | fetches serviced, waiting for load_start
// LOAD  | accepting bytes, assembling words into RAM
module prog_memory #(
   parameter int INSTR_WIDTH = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int PC_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic                   load_valid,
   input  logic [7:0]             load_byte,
   input  logic                   load_last,
   output logic                   load_ready,
   output logic                   load_done,
   output logic                   load_error,
   output logic [ADDR_WIDTH:0]    loaded_words,
   output logic                   busy,
   input  logic                   fetch_en,
   input  logic [PC_WIDTH-1:0]    fetch_addr,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid
);

   localparam int LANES  = INSTR_WIDTH / 8;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   // Wide enough for both the PC and the word count, so neither is truncated
   localparam int CMP_W  = (PC_WIDTH > ADDR_WIDTH + 1) ? PC_WIDTH : ADDR_WIDTH + 1;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t                 state;
   logic [LANE_W-1:0]      lane;
   logic [ADDR_WIDTH-1:0]  word_ptr;
   logic [INSTR_WIDTH-1:0] asm_word;
   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   logic                   accept;
   logic                   last_lane;
   logic                   word_full;
   logic [INSTR_WIDTH-1:0] next_word;
   logic [CMP_W-1:0]       cmp_addr;
   logic [CMP_W-1:0]       cmp_cnt;
   logic                   in_range;

   // A byte in the same cycle as load_start is ignored (restart wins)
   assign accept    = (state == LOAD) && load_valid && !load_start;
   assign last_lane = (lane == LANE_W'(LANES - 1));
   assign word_full = accept && last_lane;
   assign next_word = INSTR_WIDTH'({asm_word, load_byte});
   assign busy      = (state == LOAD);
   assign cmp_addr  = CMP_W'(fetch_addr);
   assign cmp_cnt   = CMP_W'(loaded_words);
   assign in_range  = (cmp_addr < cmp_cnt);

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (word_full) mem[word_ptr] <= next_word;
   end

   // Loader FSM with registered handshake and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lane         <= '0;
         word_ptr     <= '0;
         asm_word     <= '0;
         loaded_words <= '0;
         load_ready   <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
      end else begin
         load_done  <= 1'b0;
         load_error <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state        <= LOAD;
                  load_ready   <= 1'b1;
                  lane         <= '0;
                  word_ptr     <= '0;
                  loaded_words <= '0;
               end
            end
            LOAD: begin
               if (load_start) begin
                  lane         <= '0;
                  word_ptr     <= '0;
                  loaded_words <= '0;
               end else if (load_valid) begin
                  if (last_lane) begin
                     lane         <= '0;
                     word_ptr     <= word_ptr + 1'b1;
                     loaded_words <= loaded_words + 1'b1;
                     // The RAM is full after the top word, so the load ends there
                     if (load_last || (word_ptr == '1)) begin
                        state      <= IDLE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                     end
                  end else if (load_last) begin
                     state      <= IDLE;
                     load_ready <= 1'b0;
                     load_error <= 1'b1;
                     lane       <= '0;
                  end else begin
                     lane     <= lane + 1'b1;
                     asm_word <= next_word;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Fetch port: one-cycle registered read, NOP outside the loaded program
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= '0;
         instr_valid <= 1'b0;
      end else if ((state == IDLE) && fetch_en && !load_start) begin
         instr_valid <= 1'b1;
         instruction <= in_range ? mem[cmp_addr[ADDR_WIDTH-1:0]] : '0;
      end else begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prog_memory.sv
// Bench for prog_memory: a default-size instance checked through a fetch scoreboard,
// plus a 4-word instance sharing the same stimulus for the RAM-full case.
module tb_prog_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [7:0]  load_byte = 8'h00;
   logic        load_last = 1'b0;
   logic        fetch_en = 1'b0;
   logic [15:0] fetch_addr = 16'h0000;

   logic        load_ready, load_done, load_error, busy, instr_valid;
   logic [8:0]  loaded_words;
   logic [15:0] instruction;

   logic        load_ready_s, load_done_s, load_error_s, busy_s, instr_valid_s;
   logic [2:0]  loaded_words_s;
   logic [15:0] instruction_s;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0, err_cnt = 0, done_cnt_s = 0;

   logic [16:0] exp_q [$];
   logic [15:0] model_mem [256];
   int          model_cnt = 0;
   logic [15:0] prog [9] = '{16'hA40A, 16'hA801, 16'h2000, 16'h8C01, 16'hB003,
                             16'hC000, 16'h0102, 16'h7FFF, 16'hE000};
   logic [15:0] held;

   always #5 clk = ~clk;

   prog_memory #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .PC_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
      .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
      .load_done(load_done), .load_error(load_error), .loaded_words(loaded_words),
      .busy(busy), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .instruction(instruction), .instr_valid(instr_valid));

   prog_memory #(.INSTR_WIDTH(16), .ADDR_WIDTH(2), .PC_WIDTH(16)) dut_small (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
      .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready_s),
      .load_done(load_done_s), .load_error(load_error_s), .loaded_words(loaded_words_s),
      .busy(busy_s), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .instruction(instruction_s), .instr_valid(instr_valid_s));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard pop: every valid fetch result must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && instr_valid) begin
         if (exp_q.size() == 0) check_eq("unexpected_valid", 32'd1, 32'd0);
         else check_eq("fetch_data", {15'd0, instr_valid, instruction}, {15'd0, exp_q.pop_front()});
      end
   end

   // Pulse counters; busy must already be low while load_done is high
   always @(negedge clk) begin
      if (rst_n) begin
         if (load_done) begin
            done_cnt++;
            check_eq("busy_at_done", {31'd0, busy}, 32'd0);
         end
         if (load_error) err_cnt++;
         if (load_done_s) done_cnt_s++;
      end
   end

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic fetch(input logic [15:0] a);
      logic [15:0] e;
      e = (32'(a) < model_cnt) ? model_mem[a[7:0]] : 16'h0000;
      fetch_en   = 1'b1;
      fetch_addr = a;
      exp_q.push_back({1'b1, e});
      cycle();
      fetch_en = 1'b0;
   endtask

   task automatic start_load(input logic with_fetch);
      held       = instruction;
      load_start = 1'b1;
      fetch_en   = with_fetch;
      fetch_addr = 16'h0000;
      done_cnt   = 0;
      err_cnt    = 0;
      done_cnt_s = 0;
      model_cnt  = 0;
      cycle();
      load_start = 1'b0;
      fetch_en   = 1'b0;
      check_eq("ready_after_start", {31'd0, load_ready}, 32'd1);
      check_eq("busy_after_start", {31'd0, busy}, 32'd1);
      if (with_fetch) begin
         check_eq("drop_on_start_valid", {31'd0, instr_valid}, 32'd0);
         check_eq("drop_on_start_hold", {16'd0, instruction}, {16'd0, held});
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      cycle();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cycle();
      cycle();
      check_eq("rst_instruction", {16'd0, instruction}, 32'd0);
      check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("rst_ready", {31'd0, load_ready}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_words", {23'd0, loaded_words}, 32'd0);
      rst_n = 1'b1;
      cycle();

      // Empty memory: everything is NOP
      fetch(16'd0);
      fetch(16'd5);
      fetch(16'hFFFF);
      cycle();

      // Nine-word program, load_last on byte 18
      start_load(1'b0);
      for (int i = 0; i < 9; i++) begin
         check_eq("ready_in_load", {31'd0, load_ready}, 32'd1);
         send_byte(prog[i][15:8], 1'b0);
         send_byte(prog[i][7:0], i == 8);
         model_mem[i] = prog[i];
      end
      model_cnt = 9;
      cycle();
      check_eq("prog_done_cnt", done_cnt, 1);
      check_eq("prog_err_cnt", err_cnt, 0);
      check_eq("prog_words", {23'd0, loaded_words}, 32'd9);
      check_eq("prog_ready_low", {31'd0, load_ready}, 32'd0);
      for (int a = 0; a <= 9; a++) fetch(16'(a));
      fetch(16'd300);
      cycle();

      // Odd byte count ends on a partial word
      start_load(1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      model_mem[0] = 16'h1122;
      model_cnt = 1;
      cycle();
      check_eq("odd_err_cnt", err_cnt, 1);
      check_eq("odd_done_cnt", done_cnt, 0);
      check_eq("odd_words", {23'd0, loaded_words}, 32'd1);
      fetch(16'd0);
      fetch(16'd1);
      cycle();

      // Ten words with no load_last: the 4-word instance fills and stops itself
      start_load(1'b0);
      for (int i = 0; i < 20; i++) begin
         if (i == 8 || i == 9) check_eq("small_ready_low", {31'd0, load_ready_s}, 32'd0);
         send_byte(8'h40 + 8'(i), 1'b0);
      end
      cycle();
      check_eq("small_done_cnt", done_cnt_s, 1);
      check_eq("small_words", {29'd0, loaded_words_s}, 32'd4);
      check_eq("small_busy", {31'd0, busy_s}, 32'd0);
      check_eq("big_still_busy", {31'd0, busy}, 32'd1);

      // Fetch while loading is dropped and instruction holds
      held       = instruction;
      fetch_en   = 1'b1;
      fetch_addr = 16'd0;
      cycle();
      fetch_en = 1'b0;
      check_eq("drop_busy_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("drop_busy_hold", {16'd0, instruction}, {16'd0, held});

      // Restart at byte 5 (from IDLE first: end the running load cleanly)
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b1);
      cycle();
      start_load(1'b1);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
      load_start = 1'b1;
      load_valid = 1'b1;
      load_byte  = 8'hEE;
      cycle();
      load_start = 1'b0;
      load_valid = 1'b0;
      check_eq("restart_words", {23'd0, loaded_words}, 32'd0);
      send_byte(8'hBE, 1'b0);
      send_byte(8'hEF, 1'b0);
      send_byte(8'hCA, 1'b0);
      send_byte(8'hFE, 1'b1);
      model_mem[0] = 16'hBEEF;
      model_mem[1] = 16'hCAFE;
      model_cnt = 2;
      cycle();
      check_eq("restart_done_cnt", done_cnt, 1);
      check_eq("restart_words2", {23'd0, loaded_words}, 32'd2);
      fetch(16'd0);
      fetch(16'd1);
      fetch(16'd2);
      fetch(16'd1);
      cycle();
      check_eq("queue_drained", exp_q.size(), 0);

      // Reset in the middle of a load
      start_load(1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_instruction", {16'd0, instruction}, 32'd0);
      check_eq("midrst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("midrst_ready", {31'd0, load_ready}, 32'd0);
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_done", {31'd0, load_done}, 32'd0);
      check_eq("midrst_error", {31'd0, load_error}, 32'd0);
      check_eq("midrst_words", {23'd0, loaded_words}, 32'd0);
      cycle();
      rst_n = 1'b1;
      model_cnt = 0;
      cycle();
      fetch(16'd0);
      cycle();
      check_eq("final_queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_memory.md
# prog_memory

Writable, parametrised instruction memory for the 16-bit processor. It replaces the fixed case-table program ROM with a RAM that is filled at run time through a byte-stream loader port, and serves instruction fetches with one-cycle registered latency. Addresses that lie beyond the loaded program, or beyond the memory depth, return NOP (all zeros), as the fixed ROM did. It sits between the program loader (testbench or UART front end) and the processor fetch stage.

## Interface
- `INSTR_WIDTH`, 16, instruction word width; must be a multiple of 8.
- `ADDR_WIDTH`, 8, RAM index width; `DEPTH = 2**ADDR_WIDTH` words.
- `PC_WIDTH`, 16, width of the processor fetch address.

Ports:
- `clk`, input, 1, single clock; all logic is rising-edge.
- `rst_n`, input, 1, asynchronous, active-low reset.
- `load_start`, input, 1, begins or restarts a program load at word 0.
- `load_valid`, input, 1, `load_byte` is valid.
- `load_byte`, input, 8, program byte, most-significant byte of each word first.
- `load_last`, input, 1, qualifies the final byte of the program.
- `load_ready`, output, 1, a byte is accepted when `load_valid && load_ready`.
- `load_done`, output, 1, one-cycle pulse when a load completes cleanly.
- `load_error`, output, 1, one-cycle pulse when a load ends on a partial word.
- `loaded_words`, output, ADDR_WIDTH+1, number of complete words currently loaded.
- `busy`, output, 1, high while the block is not in IDLE.
- `fetch_en`, input, 1, fetch request.
- `fetch_addr`, input, PC_WIDTH, word address of the fetch.
- `instruction`, output, INSTR_WIDTH, registered fetched word.
- `instr_valid`, output, 1, `instruction` answers the request from the previous cycle.

## Operation
- Loader FSM states are IDLE and LOAD, plus a byte-lane counter `lane` (0 to INSTR_WIDTH/8-1).
- IDLE: `load_ready=0`. When `load_start=1`, go to LOAD and clear `word_ptr`, `lane` and `loaded_words`.
- LOAD: `load_ready=1`. Each accepted byte is shifted into an assembly register. When the last lane is accepted, write the word to RAM at `word_ptr`, then increment `word_ptr` and `loaded_words`.
- A load ends cleanly when either of these is accepted:
  - `load_last=1` on the last lane, or
  - the word at `DEPTH-1`.

  The FSM then returns to IDLE and pulses `load_done`.
- If `load_last=1` arrives on any other lane, the partial word is discarded. The FSM returns to IDLE, pulses `load_error`, and `loaded_words` keeps its count of complete words.
- `load_start` during LOAD restarts the load: pointer, lane and count are cleared, and the same-cycle byte is ignored.
- Fetch is serviced only in IDLE.
  - The word is RAM[`fetch_addr`] when `fetch_addr < loaded_words`. Otherwise it is 0 (NOP), including any address at or above DEPTH; the full PC_WIDTH is compared, with no truncation.
  - If `fetch_en=1` while `busy=1`, or in the same cycle as `load_start`, the request is dropped (`instr_valid=0`), and `instruction` holds its value.
- RAM contents are not cleared by reset. `loaded_words=0` makes every fetch return NOP until a load completes.

## Timing
- Reset values: `instruction=0`, `instr_valid=0`, `load_ready=0`, `load_done=0`, `load_error=0`, `busy=0`, `loaded_words=0`, state IDLE, `word_ptr=0`, `lane=0`.
- Fetch latency is 1 cycle: request at edge N gives `instruction`/`instr_valid` after edge N+1. Back-to-back fetches give one result per cycle.
- `load_ready` is a registered function of state: it rises 1 cycle after `load_start`.
- A word written on edge N is fetchable on the first cycle back in IDLE.
- `busy` falls in the same cycle as the `load_done`/`load_error` pulse.
- Reset asserted mid-load: everything returns to reset values immediately, and the partial load is lost (`loaded_words=0`).

## Test plan
- Reset, then fetch addresses 0, 5 and 0xFFFF -> `instruction=0x0000` each with `instr_valid=1`, 1 cycle after the request.
- Load the 9-word countdown program, starting with bytes A4,0A,A8,01 (word 0 = 0xA40A, word 1 = 0xA801; `load_last` on the 18th byte) -> `load_done` pulses once, `loaded_words=9`. Fetching 0..8 returns the loaded words; fetching 9 returns 0.
- Odd byte count (3 bytes, `load_last` on the third) -> `load_error` pulses once, `loaded_words=1`, and fetch 1 returns 0.
- With ADDR_WIDTH=2, stream 10 words without `load_last` -> auto-done after word 3, `loaded_words=4`, and `load_ready=0` for bytes 9 and 10.
- `load_start` at byte 5, then reload 2 words -> `loaded_words=2`, and fetch 2 returns 0.
- `fetch_en` during LOAD and on the `load_start` cycle -> `instr_valid=0`. Assert `rst_n` low mid-load -> all outputs at reset values immediately.
